// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default address width.
// Used by both the write_ptr and read_ptr pointer blocks.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 3;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Parameterised Gray-to-binary converter (combinational).
// Used by write_ptr when WRITE_PTR_ALMOST_FULL_EN is defined.
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o = W'(gray2bin(32'(gray_i)));

endmodule

// File: rtl/write_ptr.sv
// Write-domain pointer and full flag of the async FIFO.
// Optional almost_full_o when WRITE_PTR_ALMOST_FULL_EN is defined.
module write_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   wr_ptr_2_i,
  input  logic                 inc_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
`ifdef WRITE_PTR_ALMOST_FULL_EN
  output logic                 almost_full_o,
`endif
  output logic                 fifo_full_o
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          full_q, full_d;
  logic [PW-1:0] full_cmp;

  assign bin_d = bin_q + {{ADDR_SIZE{1'b0}}, inc_i & ~full_q};
  assign ptr_d = PW'(bin2gray(32'(bin_d)));

  // Full when writer is one lap ahead: top two Gray bits inverted
  assign full_cmp = {~wr_ptr_2_i[ADDR_SIZE:ADDR_SIZE-1],
                     wr_ptr_2_i[ADDR_SIZE-2:0]};
  assign full_d   = (ptr_d == full_cmp);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      ptr_q  <= '0;
      full_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      ptr_q  <= ptr_d;
      full_q <= full_d;
    end
  end

  assign ptr_o       = ptr_q;
  assign addr_o      = bin_q[ADDR_SIZE-1:0];
  assign fifo_full_o = full_q;

`ifdef WRITE_PTR_ALMOST_FULL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] occ_d;
  logic          af_q, af_d;

  gray_to_bin #(
    .W(PW)
  ) u_g2b (
    .gray_i(wr_ptr_2_i),
    .bin_o (rbin)
  );

  assign occ_d = bin_d - rbin;
  assign af_d  = (occ_d >= PW'((1 << ADDR_SIZE) - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full_o = af_q;
`endif

endmodule

// File: tb/tb_write_ptr.sv
// Self-checking bench for write_ptr (ADDR_SIZE=3), occupancy-count model.
// Almost-full checks compiled in with WRITE_PTR_ALMOST_FULL_EN.
module tb_write_ptr;

  localparam int A  = 3;
  localparam int PW = A + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          inc_i = 1'b0;
  logic [PW-1:0] rptr = '0;
  logic [PW-1:0] ptr_o;
  logic [A-1:0]  addr_o;
  logic          full_o;
`ifdef WRITE_PTR_ALMOST_FULL_EN
  logic          af_o;
`endif

  write_ptr #(.ADDR_SIZE(A)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wr_ptr_2_i (rptr),
    .inc_i      (inc_i),
    .ptr_o      (ptr_o),
    .addr_o     (addr_o),
`ifdef WRITE_PTR_ALMOST_FULL_EN
    .almost_full_o(af_o),
`endif
    .fifo_full_o(full_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: total writes w and reads r as plain integers
  int            w = 0;
  int            r = 0;
  bit            fm = 0;
  logic [PW-1:0] prev_ptr = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (w=%0d r=%0d)",
               tag, got, exp, w, r);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % 16);
    return b ^ (b >> 1);
  endfunction

  function automatic int occ();
    return (w - r) & 15;
  endfunction

  task automatic step(input bit inc, input bit rd);
    inc_i = inc;
    if (rd && occ() != 0) begin
      r++;
      rptr = gray(r);
    end
    @(posedge clk);
    #1;
    if (inc && !fm) w++;
    fm = (occ() == 8);
    check("ptr", 32'(ptr_o), 32'(gray(w)));
    check("addr", 32'(addr_o), 32'(w % 8));
    check("full", 32'(full_o), 32'(fm));
    check("gray1", 32'($countones(prev_ptr ^ ptr_o) <= 1), 32'd1);
`ifdef WRITE_PTR_ALMOST_FULL_EN
    check("afull", 32'(af_o), 32'(occ() >= 7));
`endif
    prev_ptr = ptr_o;
  endtask

  initial begin
    #1;
    check("rst_ptr", 32'(ptr_o), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Fill from empty
    for (int i = 0; i < 8; i++) step(1, 0);
    check("fill_ptr", 32'(ptr_o), 32'hC);
    check("fill_addr", 32'(addr_o), 32'd0);
    check("fill_full", 32'(full_o), 32'd1);

    // Hold while full
    for (int i = 0; i < 5; i++) step(1, 0);
    check("hold_ptr", 32'(ptr_o), 32'hC);

    // Drain one slot
    step(1, 1);
    check("drain_full0", 32'(full_o), 32'd0);
    step(1, 0);
    check("drain_ptr", 32'(ptr_o), 32'hD);
    check("drain_full1", 32'(full_o), 32'd1);

    // Random traffic covering several wraps
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 2) == 1);
    end

    // Asynchronous reset mid-count
    #3;
    rst_i = 1'b1;
    rptr  = '0;
    #1;
    check("arst_ptr", 32'(ptr_o), 32'd0);
    check("arst_addr", 32'(addr_o), 32'd0);
    check("arst_full", 32'(full_o), 32'd0);
`ifdef WRITE_PTR_ALMOST_FULL_EN
    check("arst_af", 32'(af_o), 32'd0);
`endif
    w = 0;
    r = 0;
    fm = 0;
    prev_ptr = '0;
    @(negedge clk);
    rst_i = 1'b0;

    // Fill again; almost-full after 7th write, full after 8th
    for (int i = 0; i < 7; i++) step(1, 0);
    check("f7_full", 32'(full_o), 32'd0);
`ifdef WRITE_PTR_ALMOST_FULL_EN
    check("f7_af", 32'(af_o), 32'd1);
`endif
    step(1, 0);
    check("f8_full", 32'(full_o), 32'd1);

    // Heavy-read random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 2) == 1, ($urandom % 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
